// File: rtl/instruction_queue.sv
// Fetch-to-decode instruction buffer: circular FIFO of {pc, inst} with wrap-bit
// pointers, backpressure via full, and a single-cycle flush for branch redirects.
module instruction_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_inst,
  output logic             full,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_inst,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   head;
  logic [PTR_W:0]   tail;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic             empty;
  logic             enq_fire;
  logic             deq_fire;
  logic             clear;

  // Occupancy decode from registered pointers only; no input reaches an output.
  assign empty    = (head == tail);
  assign full     = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);
  assign count    = tail - head;
  assign clear    = rst || flush;
  assign enq_fire = enq_valid && !full && !clear;
  assign deq_fire = deq_ready && !empty && !clear;

  always_ff @(posedge clk) begin
    if (clear) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_fire) tail <= tail + PTR_ONE;
      if (deq_fire) head <= head + PTR_ONE;
    end
  end

  // Entry storage carries data only and is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[tail[PTR_W-1:0]]   <= enq_pc;
      inst_mem[tail[PTR_W-1:0]] <= enq_inst;
    end
  end

  assign deq_valid = !empty;
  assign deq_pc    = empty ? 32'd0 : pc_mem[head[PTR_W-1:0]];
  assign deq_inst  = empty ? 32'd0 : inst_mem[head[PTR_W-1:0]];

endmodule

// File: tb/tb_instruction_queue.sv
// Randomised and directed bench for instruction_queue with a queue-based
// reference model and a negedge monitor that scores every cycle.
module tb_instruction_queue;
  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic [31:0]      enq_pc = '0;
  logic [31:0]      enq_inst = '0;
  logic             full;
  logic             deq_ready = 1'b0;
  logic             deq_valid;
  logic [31:0]      deq_pc;
  logic [31:0]      deq_inst;
  logic [PTR_W:0]   count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  int   model_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   checking = 1'b0;

  instruction_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst),
    .full(full), .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_pc(deq_pc), .deq_inst(deq_inst), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  // Reference model: a plain queue of accepted entries, updated on each edge.
  always @(posedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      int d;
      int e;
      d = (deq_ready && model_cnt > 0) ? 1 : 0;
      e = (enq_valid && model_cnt < DEPTH) ? 1 : 0;
      if (e == 1) exp_q.push_back('{pc: enq_pc, inst: enq_inst});
      model_cnt = model_cnt + e - d;
    end
  end

  // Monitor: compare presented state against the model; pop on each consumption.
  always @(negedge clk) begin
    if (checking) begin
      chk("count", 32'(count), 32'(model_cnt));
      chk("full", 32'(full), 32'(model_cnt == DEPTH));
      chk("deq_valid", 32'(deq_valid), 32'(model_cnt > 0));
      if (model_cnt > 0 && exp_q.size() > 0) begin
        chk("deq_pc", deq_pc, exp_q[0].pc);
        chk("deq_inst", deq_inst, exp_q[0].inst);
        if (deq_ready) void'(exp_q.pop_front());
      end else begin
        chk("deq_pc_empty", deq_pc, 32'd0);
        chk("deq_inst_empty", deq_inst, 32'd0);
      end
    end
  end

  task automatic step(input logic e, input logic [31:0] pc, input logic d,
                      input logic f, input logic r);
    enq_valid = e;
    enq_pc    = pc;
    enq_inst  = $urandom;
    deq_ready = d;
    flush     = f;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int peak;
    logic [31:0] pc;

    // Reset then idle
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checking = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Fill to full, 17th dropped, then drain
    for (int i = 0; i < 16; i++) step(1'b1, 32'h6000_0000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    step(1'b1, 32'h6000_0040, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", deq_pc, 32'h6000_0000 + 32'(4 * i));
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 32'(deq_valid), 32'd0);

    // Wrap-around
    for (int i = 0; i < 10; i++) step(1'b1, 32'h6000_0100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    peak = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h6000_0200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      if (int'(count) > peak) peak = int'(count);
    end
    chk("wrap_peak", 32'(peak), 32'd12);
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Simultaneous ops at count=5, then at full
    for (int i = 0; i < 5; i++) step(1'b1, 32'h6000_0300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 32'h6000_0400 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    chk("simul_count", 32'(count), 32'd5);
    for (int i = 0; i < 11; i++) step(1'b1, 32'h6000_0500 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6000_0600, 1'b1, 1'b0, 1'b0);
    chk("full_simul_count", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Flush priority
    for (int i = 0; i < 7; i++) step(1'b1, 32'h6000_0700 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6000_1000, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(deq_valid), 32'd0);
    step(1'b1, 32'h6000_2000, 1'b0, 1'b0, 1'b0);
    chk("post_flush_pc", deq_pc, 32'h6000_2000);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation
    for (int i = 0; i < 9; i++) step(1'b1, 32'h6000_0800 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6000_0900, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_full", 32'(full), 32'd0);
    chk("rst_mid_valid", 32'(deq_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset
    pc = 32'h7000_0000;
    for (int i = 0; i < 3000; i++) begin
      logic e;
      logic d;
      logic f;
      logic r;
      e = ($urandom_range(0, 99) < 60);
      d = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 2);
      r = ($urandom_range(0, 199) < 1);
      step(e, pc, d, f, r);
      pc = pc + 32'd4;
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_queue.md
# instruction_queue

Circular FIFO between the fetch stage and decode. It buffers fetched instruction words with their PCs and drives backpressure, via `full`, into the fetch stage's `stall_inst` input. On a redirect it flushes all in-flight entries so decode never sees wrong-path instructions.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, minimum 2.
- `PTR_W`, $clog2(DEPTH), index width; pointers carry one extra wrap bit.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all entries (branch redirect).
- `enq_valid`  in  1  fetch presents an instruction this cycle.
- `enq_pc`  in  32  PC of the enqueued instruction (`fetch_pc_curr`).
- `enq_inst`  in  32  instruction word from imem.
- `full`  out  1  no free entry; fetch must hold its PC and drive `stall_inst`.
- `deq_ready`  in  1  decode consumes the head entry this cycle.
- `deq_valid`  out  1  head entry is valid.
- `deq_pc`  out  32  PC of the head entry.
- `deq_inst`  out  32  instruction word of the head entry.
- `count`  out  PTR_W+1  occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {pc, inst}. Storage is not reset.
- Pointers: `head` and `tail`, each PTR_W+1 bits, with the MSB as wrap bit.
  - `count = tail - head`, modulo 2^(PTR_W+1).
  - `empty` when head == tail.
  - `full` when the index bits are equal and the wrap bits differ.
- Enqueue fires when `enq_valid && !full`:
  - write {enq_pc, enq_inst} at tail[PTR_W-1:0];
  - tail increments and wraps naturally.
- `enq_valid` while `full`: the request is dropped. Fetch is responsible for re-presenting it.
- Dequeue fires when `deq_ready && deq_valid`; head increments.
- Simultaneous enqueue and dequeue:
  - both fire and count is unchanged;
  - when full, enqueue is still refused, because `full` reflects the current state and there is no same-cycle slot reuse.
- Empty: there is no bypass. An enqueued word appears at the outputs on the next cycle.
- `flush` has priority over everything else:
  - head <= 0, tail <= 0;
  - any enq/deq in the same cycle is ignored;
  - next cycle count=0, deq_valid=0, full=0.
- `deq_valid = !empty`.
- `deq_pc` and `deq_inst` read the head entry when valid, and are forced to 0 when empty.
- Reset: head=0, tail=0. Outputs after reset: deq_valid=0, full=0, count=0, deq_pc=0, deq_inst=0.
- `rst` mid-operation behaves exactly like flush. `rst` takes priority over `flush`.

## Timing
- Enqueue-to-visible latency is 1 cycle: an entry written at edge N is presented at deq_* after edge N.
- `full`, `count`, `deq_valid`, `deq_pc` and `deq_inst` are functions of registered state only. There is no combinational path from enq_* or deq_ready to any output.
- Throughput is one enqueue plus one dequeue per cycle sustained whenever 0 < count < DEPTH.
- `full` deasserts the cycle after a dequeue from a full queue. Fetch may resume on that cycle.
- Flush-to-empty takes 1 cycle. An enqueue presented on the cycle after flush is accepted normally.
- Wrap-around needs no special case: index bits roll over from DEPTH-1 to 0 and the wrap bit toggles.

## Test plan
- Reset then idle:
  - assert rst for 2 cycles with enq_valid=0;
  - required: count=0, deq_valid=0, full=0, deq_pc=0, deq_inst=0.
- Fill to full, then drain, with DEPTH=16 and deq_ready=0:
  - enqueue PCs 0x60000000, 0x60000004, … 0x6000003C;
  - required: full=1 and count=16 after the 16th edge; a 17th enqueue with pc 0x60000040 is dropped;
  - then set deq_ready=1: outputs are 0x60000000 … 0x6000003C in order, and deq_valid falls after the 16th pop.
- Wrap-around:
  - enqueue 10, dequeue 10, enqueue 12;
  - required: the 12 entries dequeue in order with correct {pc, inst} pairs across the index rollover, and count peaks at 12.
- Simultaneous ops:
  - at count=5, enq_valid=1 and deq_ready=1 for 20 cycles;
  - required: count stays 5 and the output order is preserved;
  - at count=16, both asserted for 1 cycle: required count=15 after the edge and the enqueued word is not stored.
- Flush priority:
  - at count=7, assert flush together with enq_valid=1 (pc 0x60001000) and deq_ready=1;
  - required next cycle: count=0, deq_valid=0;
  - enqueuing 0x60002000 on the following cycle makes deq_pc=0x60002000 one cycle later.
- Reset mid-operation:
  - at count=9, assert rst together with flush=0 and enq_valid=1;
  - required: count=0, full=0, deq_valid=0, and no stale entry ever reappears on deq_*.
